// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer and IF/MEM shared memory-port arbiter.
// Define PIPE_CTRL_PERF_EN to build the saturating stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int STALL_W = 6,
    parameter int PERF_W  = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               if_req,
    input  logic               mem_req,
    input  logic               mem_done,
    output logic               port_start,
    output logic               port_sel_mem,
    output logic               if_ack,
    output logic               mem_ack,
    input  logic               stallreq_id,
    input  logic               stallreq_ex,
    input  logic               branch_flush,
    output logic [STALL_W-1:0] stall,
    output logic               flush,
    output logic [PERF_W-1:0]  perf_stall_cnt
);
    typedef enum logic [1:0] {IDLE, IF_ACC, MEM_ACC} state_t;
    state_t r_state, w_state_nxt;
    logic r_drop_fetch, r_flush_pending;
    logic w_start_nxt, w_req4, w_req1, w_s3, w_s2, w_s1;
    // stall[3] never depends on flush, which keeps flush -> if_ack -> req1 loop-free
    assign mem_ack = (r_state == MEM_ACC) && mem_done;
    assign w_req4  = mem_req && !mem_ack;
    assign w_s3    = w_req4 || stallreq_ex;
    assign flush   = (branch_flush || r_flush_pending) && !w_s3;
    assign if_ack  = (r_state == IF_ACC) && mem_done && !r_drop_fetch && !flush;
    assign w_req1  = if_req && !if_ack && !flush;
    assign w_s2    = w_s3 || stallreq_id;
    assign w_s1    = w_s2 || w_req1;
    assign stall   = STALL_W'({w_req4, w_s3, w_s2, w_s1, w_s1});
    always_comb begin
        w_state_nxt = r_state;
        w_start_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (mem_req) begin
                    w_state_nxt = MEM_ACC;
                    w_start_nxt = 1'b1;
                end else if (if_req && !flush) begin
                    w_state_nxt = IF_ACC;
                    w_start_nxt = 1'b1;
                end
            end
            default: w_state_nxt = mem_done ? IDLE : r_state;
        endcase
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state         <= IDLE;
            port_start      <= 1'b0;
            port_sel_mem    <= 1'b0;
            r_drop_fetch    <= 1'b0;
            r_flush_pending <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            port_start      <= w_start_nxt;
            port_sel_mem    <= w_state_nxt == MEM_ACC;
            r_drop_fetch    <= (r_state == IF_ACC) && !mem_done && (r_drop_fetch || flush);
            r_flush_pending <= (branch_flush && w_s3) || (r_flush_pending && !flush);
        end
    end
`ifdef PIPE_CTRL_PERF_EN
    logic [PERF_W-1:0] r_perf;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_perf <= '0;
        else if (stall[0] && r_perf != '1)
            r_perf <= r_perf + 1'b1;
    end
    assign perf_stall_cnt = r_perf;
`else
    assign perf_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors with queued expectations, checked by a per-cycle monitor.
module tb_pipe_hazard_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b0;
    logic if_req = 0, mem_req = 0, mem_done = 0, stallreq_id = 0, stallreq_ex = 0, branch_flush = 0;
    logic port_start, port_sel_mem, if_ack, mem_ack, flush;
    logic [5:0] stall;
    logic [31:0] perf_stall_cnt;
    typedef struct {
        int id;
        logic [10:0] v;
        logic [31:0] perf;
    } exp_t;
    exp_t q[$];
    int n_pass = 0, n_total = 0, n_id = 0;
    logic [31:0] pm = 0;
    pipe_hazard_ctrl #(.STALL_W(6), .PERF_W(32)) dut (
        .clock(clock), .reset(reset), .if_req(if_req), .mem_req(mem_req), .mem_done(mem_done),
        .port_start(port_start), .port_sel_mem(port_sel_mem), .if_ack(if_ack), .mem_ack(mem_ack),
        .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex), .branch_flush(branch_flush),
        .stall(stall), .flush(flush), .perf_stall_cnt(perf_stall_cnt)
    );
    always #5 clock = ~clock;
    task automatic cyc(input logic rs, ir, mr, md, sid, sex, bf, eps, epsm, eia, ema,
                       input logic [5:0] est, input logic efl);
        exp_t e;
        @(posedge clock);
        #1;
        reset = rs; if_req = ir; mem_req = mr; mem_done = md;
        stallreq_id = sid; stallreq_ex = sex; branch_flush = bf;
        if (!rs) pm = 0;
        e.id = n_id++;
        e.v = {eps, epsm, eia, ema, est, efl};
`ifdef PIPE_CTRL_PERF_EN
        e.perf = pm;
`else
        e.perf = 0;
`endif
        q.push_back(e);
        if (rs && est[0]) pm = pm + 1;
    endtask
    always @(negedge clock) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_total++;
            if ({port_start, port_sel_mem, if_ack, mem_ack, stall, flush} === e.v && perf_stall_cnt === e.perf)
                n_pass++;
            else
                $display("FAIL vec%0d: got ps/sel/ifa/mema/stall/flush=%b perf=%0d, expected %b perf=%0d",
                         e.id, {port_start, port_sel_mem, if_ack, mem_ack, stall, flush}, perf_stall_cnt, e.v, e.perf);
        end
    end
    initial begin
        cyc(0,0,0,0,0,0,0, 0,0,0,0, 6'b000000,0);
        // simultaneous requests: MEM wins, IF follows after one IDLE cycle
        cyc(1,1,1,0,0,0,0, 0,0,0,0, 6'b011111,0);
        cyc(1,1,1,0,0,0,0, 1,1,0,0, 6'b011111,0);
        cyc(1,1,1,1,0,0,0, 0,1,0,1, 6'b000011,0);
        cyc(1,1,0,0,0,0,0, 0,0,0,0, 6'b000011,0);
        cyc(1,1,0,0,0,0,0, 1,0,0,0, 6'b000011,0);
        cyc(1,1,0,0,0,0,0, 0,0,0,0, 6'b000011,0);
        cyc(1,1,0,0,0,0,0, 0,0,0,0, 6'b000011,0);
        cyc(1,1,0,1,0,0,0, 0,0,1,0, 6'b000000,0);
        cyc(1,0,0,0,0,0,0, 0,0,0,0, 6'b000000,0);
        // branch flush kills an in-flight fetch
        cyc(1,1,0,0,0,0,0, 0,0,0,0, 6'b000011,0);
        cyc(1,1,0,0,0,0,1, 1,0,0,0, 6'b000000,1);
        cyc(1,0,0,0,0,0,0, 0,0,0,0, 6'b000000,0);
        cyc(1,0,0,1,0,0,0, 0,0,0,0, 6'b000000,0);
        cyc(1,1,0,0,0,0,0, 0,0,0,0, 6'b000011,0);
        cyc(1,1,0,1,0,0,0, 1,0,1,0, 6'b000000,0);
        cyc(1,0,0,0,0,0,0, 0,0,0,0, 6'b000000,0);
        // flush deferred behind an EX stall
        repeat (4) cyc(1,0,0,0,0,1,1, 0,0,0,0, 6'b001111,0);
        cyc(1,0,0,0,0,0,0, 0,0,0,0, 6'b000000,1);
        cyc(1,0,0,0,0,0,0, 0,0,0,0, 6'b000000,0);
        // hazard masks, and mem_done ignored in IDLE
        cyc(1,0,0,0,1,0,0, 0,0,0,0, 6'b000111,0);
        cyc(1,0,0,0,1,1,0, 0,0,0,0, 6'b001111,0);
        cyc(1,0,0,1,0,0,0, 0,0,0,0, 6'b000000,0);
        // async reset in the middle of a MEM access
        cyc(1,0,1,0,0,0,0, 0,0,0,0, 6'b011111,0);
        cyc(1,0,1,0,0,0,0, 1,1,0,0, 6'b011111,0);
        cyc(0,0,0,0,0,0,0, 0,0,0,0, 6'b000000,0);
        cyc(1,0,0,1,0,0,0, 0,0,0,0, 6'b000000,0);
        cyc(1,1,0,0,0,0,0, 0,0,0,0, 6'b000011,0);
        cyc(1,1,0,1,0,0,0, 1,0,1,0, 6'b000000,0);
        cyc(1,0,0,0,0,0,0, 0,0,0,0, 6'b000000,0);
        repeat (3) @(posedge clock);
        if (q.size() != 0) begin
            n_total++;
            $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
